// File: rtl/xpb_table_gen_if.sv
// Control, status and read-port bundle for the xpb table generator.
// master drives the request and read index; slave is the generator.
interface xpb_table_gen_if #(
    parameter int WIDTH      = 1024,
    parameter int DIGIT_BITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      base;
    logic [WIDTH-1:0]      modulus;
    logic                  busy;
    logic                  done;
    logic                  ready;
    logic                  err;
    logic [DIGIT_BITS-1:0] rd_idx;
    logic [WIDTH-1:0]      rd_data;

    modport master (
        output start, base, modulus, rd_idx,
        input  busy, done, ready, err, rd_data
    );

    modport slave (
        input  start, base, modulus, rd_idx,
        output busy, done, ready, err, rd_data
    );
endinterface

// File: rtl/xpb_table_gen.sv
// Builds table[j] = j*B mod M one entry per clock (33 cycles start->done) and serves it
// on a 1-cycle registered read port; start is dropped while busy, no other backpressure.
module xpb_table_gen #(
    parameter int WIDTH      = 1024,
    parameter int DIGIT_BITS = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    xpb_table_gen_if.slave bus
);
    localparam int ENTRIES = 1 << DIGIT_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [WIDTH-1:0]      b_q;
    logic [WIDTH-1:0]      m_q;
    logic [WIDTH-1:0]      acc;
    logic [WIDTH-1:0]      acc_nxt;
    logic [WIDTH:0]        sum;
    logic [DIGIT_BITS-1:0] cnt;
    logic                  err_q;
    logic                  done_q;
    logic                  start_acc;
    logic                  bad_args;
    logic                  last;
    logic [WIDTH-1:0]      rd_q;
    logic                  busy_o;
    logic                  ready_o;
    logic                  err_o;
    logic                  done_o;
    logic [WIDTH-1:0]      table_mem [ENTRIES];

    assign start_acc = bus.start && (state != ST_GEN);
    assign bad_args  = (bus.base >= bus.modulus) || (bus.modulus == '0);
    assign last      = &cnt;

    // acc < M and B < M, so one conditional subtract keeps acc in range;
    // the extra sum bit absorbs the carry when M is close to 2^WIDTH.
    assign sum     = {1'b0, acc} + {1'b0, b_q};
    assign acc_nxt = (sum >= {1'b0, m_q}) ? WIDTH'(sum - {1'b0, m_q}) : sum[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_nxt = bad_args ? ST_DONE : ST_GEN;
                end
            end
            ST_GEN: begin
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state == ST_GEN);
        ready_o = (state == ST_DONE) && !err_q;
        err_o   = err_q;
        done_o  = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q    <= '0;
            m_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // An error restart from DONE stays in DONE but must still pulse done.
            done_q <= (state_nxt == ST_DONE) && ((state != ST_DONE) || start_acc);
            if (start_acc) begin
                b_q   <= bus.base;
                m_q   <= bus.modulus;
                acc   <= '0;
                cnt   <= '0;
                err_q <= bad_args;
            end else if (state == ST_GEN) begin
                acc <= acc_nxt;
                cnt <= cnt + DIGIT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_GEN) begin
            table_mem[cnt] <= acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= table_mem[bus.rd_idx];
        end
    end

    assign bus.busy    = busy_o;
    assign bus.ready   = ready_o;
    assign bus.err     = err_o;
    assign bus.done    = done_o;
    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_xpb_table_gen.sv
// Randomized bench for xpb_table_gen: a 1024-bit instance and an 8-bit instance checked
// against a direct j*B mod M model, with status sampled 1 time unit after each clock edge.
module tb_xpb_table_gen;
    localparam int W  = 1024;
    localparam int DB = 5;
    localparam int N  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    xpb_table_gen_if #(.WIDTH(W), .DIGIT_BITS(DB)) bus ();
    xpb_table_gen_if #(.WIDTH(8), .DIGIT_BITS(DB)) bus8 ();

    xpb_table_gen #(.WIDTH(W), .DIGIT_BITS(DB)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    xpb_table_gen #(.WIDTH(8), .DIGIT_BITS(DB)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_tab [N];
    logic [W-1:0] got_tab [N];
    logic [7:0]   got8    [N];

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] stat();
        return {bus.busy, bus.done, bus.ready, bus.err};
    endfunction

    function automatic logic [3:0] stat8();
        return {bus8.busy, bus8.done, bus8.ready, bus8.err};
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: each entry straight from its definition, no running accumulator.
    task automatic model_fill(input logic [W-1:0] b, input logic [W-1:0] m);
        logic [W+15:0] p;
        for (int j = 0; j < N; j++) begin
            p = (W + 16)'(b) * (W + 16)'(j);
            exp_tab[j] = W'(p % (W + 16)'(m));
        end
    endtask

    task automatic pulse(input logic [W-1:0] b, input logic [W-1:0] m);
        bus.base    = b;
        bus.modulus = m;
        bus.start   = 1'b1;
        cyc();
        bus.start   = 1'b0;
    endtask

    // Back-to-back reads; the sample is taken after the index has already moved on.
    task automatic read_table();
        bus.rd_idx = '0;
        cyc();
        for (int j = 0; j < N; j++) begin
            bus.rd_idx = DB'(j + 1);
            #1;
            got_tab[j] = bus.rd_data;
            cyc();
        end
    endtask

    task automatic test_reset();
        cyc(2);
        n_cmp++;
        if (stat() !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_status: got %b want 0000", stat());
        end
        n_cmp++;
        if (bus.rd_data !== '0) begin
            n_bad++;
            $display("FAIL reset_rd_data: got lo %h want 0", bus.rd_data[63:0]);
        end
        n_cmp++;
        if ({stat8(), bus8.rd_data} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_w8: got %h want 000", {stat8(), bus8.rd_data});
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_small();
        model_fill(W'(3), W'(7));
        pulse(W'(3), W'(7));
        n_cmp++;
        if (stat() !== 4'b1000) begin
            n_bad++;
            $display("FAIL small_t1: got %b want 1000", stat());
        end
        cyc(31);
        n_cmp++;
        if (stat() !== 4'b1000) begin
            n_bad++;
            $display("FAIL small_t32: got %b want 1000", stat());
        end
        cyc();
        n_cmp++;
        if (stat() !== 4'b0110) begin
            n_bad++;
            $display("FAIL small_t33: got %b want 0110", stat());
        end
        cyc();
        n_cmp++;
        if (stat() !== 4'b0010) begin
            n_bad++;
            $display("FAIL small_t34: got %b want 0010", stat());
        end
        read_table();
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (got_tab[j] !== exp_tab[j]) begin
                n_bad++;
                $display("FAIL small_entry[%0d]: got %0d want %0d", j, got_tab[j][31:0], exp_tab[j][31:0]);
            end
        end
        n_cmp++;
        if (got_tab[31] !== W'(2)) begin
            n_bad++;
            $display("FAIL small_entry31_const: got %0d want 2", got_tab[31][31:0]);
        end
    endtask

    task automatic test_error(input logic [W-1:0] b, input logic [W-1:0] m, input string tag);
        pulse(b, m);
        n_cmp++;
        if (stat() !== 4'b0101) begin
            n_bad++;
            $display("FAIL %s_t1: got %b want 0101", tag, stat());
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_cmp++;
            if (stat() !== 4'b0001) begin
                n_bad++;
                $display("FAIL %s_hold%0d: got %b want 0001", tag, k, stat());
            end
        end
        read_table();
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (got_tab[j] !== exp_tab[j]) begin
                n_bad++;
                $display("FAIL %s_kept[%0d]: got lo %h want lo %h", tag, j, got_tab[j][63:0], exp_tab[j][63:0]);
            end
        end
    endtask

    // Full generation with random or corner operands; optional ignored start at t+10.
    task automatic run_full(input logic [W-1:0] b, input logic [W-1:0] m, input bit poke, input string tag);
        model_fill(b, m);
        pulse(b, m);
        n_cmp++;
        if (stat() !== 4'b1000) begin
            n_bad++;
            $display("FAIL %s_t1: got %b want 1000", tag, stat());
        end
        if (poke) begin
            cyc(9);
            bus.base    = rand_wide() >> 1;
            bus.modulus = rand_wide();
            bus.start   = 1'b1;
            cyc();
            bus.start   = 1'b0;
            cyc(22);
        end else begin
            cyc(32);
        end
        n_cmp++;
        if (stat() !== 4'b0110) begin
            n_bad++;
            $display("FAIL %s_t33: got %b want 0110", tag, stat());
        end
        read_table();
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (got_tab[j] !== exp_tab[j]) begin
                n_bad++;
                $display("FAIL %s_entry[%0d]: got hi %h lo %h want hi %h lo %h", tag, j,
                         got_tab[j][W-1 -: 64], got_tab[j][63:0], exp_tab[j][W-1 -: 64], exp_tab[j][63:0]);
            end
        end
    endtask

    task automatic test_wide_sum8();
        int exp8;
        bus8.base    = 8'd250;
        bus8.modulus = 8'd251;
        bus8.start   = 1'b1;
        cyc();
        bus8.start   = 1'b0;
        cyc(32);
        n_cmp++;
        if (stat8() !== 4'b0110) begin
            n_bad++;
            $display("FAIL w8_t33: got %b want 0110", stat8());
        end
        bus8.rd_idx = '0;
        cyc();
        for (int j = 0; j < N; j++) begin
            bus8.rd_idx = DB'(j + 1);
            #1;
            got8[j] = bus8.rd_data;
            cyc();
        end
        for (int j = 0; j < N; j++) begin
            exp8 = (j * 250) % 251;
            n_cmp++;
            if (got8[j] !== 8'(exp8)) begin
                n_bad++;
                $display("FAIL w8_entry[%0d]: got %0d want %0d", j, got8[j], exp8);
            end
        end
        n_cmp++;
        if ({got8[1], got8[2], got8[31]} !== {8'd250, 8'd249, 8'd220}) begin
            n_bad++;
            $display("FAIL w8_corner: got %0d %0d %0d want 250 249 220", got8[1], got8[2], got8[31]);
        end
    endtask

    task automatic test_reset_mid_gen();
        logic [W-1:0] m;
        pulse(rand_wide() >> 4, rand_wide());
        cyc(14);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (stat() !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstmid_edge: got %b want 0000", stat());
        end
        cyc();
        n_cmp++;
        if (stat() !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstmid_held: got %b want 0000", stat());
        end
        cyc();
        rst_n = 1'b1;
        cyc(3);
        n_cmp++;
        if (stat() !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstmid_idle: got %b want 0000", stat());
        end
        m = rand_wide() | {1'b1, {(W-1){1'b0}}};
        run_full(rand_wide() % m, m, 1'b0, "rstmid_new");
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.modulus  = '0;
        bus.rd_idx   = '0;
        bus8.start   = 1'b0;
        bus8.base    = '0;
        bus8.modulus = '0;
        bus8.rd_idx  = '0;

        test_reset();
        test_small();
        test_error(W'(7), W'(7), "err_eq");
        test_error(W'(5), W'(0), "err_m0");
        test_wide_sum8();
        begin
            logic [W-1:0] m;
            m = rand_wide() | {1'b1, {(W-1){1'b0}}};
            run_full(rand_wide() % m, m, 1'b1, "ignored_start");
            // Restart straight from DONE: ready must drop the next cycle.
            m = {W{1'b1}};
            run_full(m - 1, m, 1'b0, "b2b_allones");
            for (int i = 0; i < 3; i++) begin
                m = rand_wide();
                if (m == '0) m = W'(1);
                run_full(rand_wide() % m, m, 1'b0, "rand_full");
            end
        end
        test_reset_mid_gen();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
